// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, adaptor state encoding and address helper for the
// cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } adaptor_state_e;

  // Clears the byte-within-line offset so memory always sees a line-aligned address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line request from the arbiter into a 4-beat 64-bit
// burst on the memory port, beat 0 being the lowest 64 bits of the line.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  adaptor_state_e r_state;
  adaptor_state_e w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [LINE_W-1:0]  r_line;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_read;
  logic               r_write;
  logic               r_resp;

  logic               w_last_beat;
  logic [LINE_W-1:0]  w_rd_line;
  logic [BURST_W-1:0] w_wr_beat;

  assign w_last_beat = resp_i && (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Write has priority when the arbiter raises both requests at once.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (write_i) begin
          w_state_next = ST_WR;
        end else if (read_i) begin
          w_state_next = ST_RD;
        end
      end
      ST_RD: begin
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_WR: begin
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Buffer contents with the incoming read beat dropped into its slot.
  always_comb begin
    w_rd_line = r_buf;
    w_rd_line[r_cnt*BURST_W +: BURST_W] = burst_i;
  end

  assign w_wr_beat = r_buf[r_cnt*BURST_W +: BURST_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_read  <= (w_state_next == ST_RD);
      r_write <= (w_state_next == ST_WR);
      r_resp  <= (w_state_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (write_i || read_i) begin
            r_addr <= line_align(address_i);
            r_cnt  <= '0;
          end
          if (write_i) begin
            r_buf <= line_i;
          end
        end
        ST_RD: begin
          if (resp_i) begin
            r_buf <= w_rd_line;
            r_cnt <= r_cnt + 1'b1;
          end
          // line_o only changes once a full line has been assembled.
          if (w_last_beat) begin
            r_line <= w_rd_line;
          end
        end
        ST_WR: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign line_o    = r_line;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;
  assign burst_o   = r_write ? w_wr_beat : '0;

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst) !(read_o && write_o));

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a behavioural memory that
// serves/absorbs bursts with random stalls, checked against line-level expectations.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [LINE_W-1:0]  line_i = '0;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i = '0;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;

  int numCompared = 0;
  int numMismatched = 0;
  logic [LINE_W-1:0] lastReadLine = '0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [LINE_W-1:0] randomLine();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < LINE_W / 32; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Idle cycles with random resp_i noise, which the adaptor must ignore.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_resp_low", resp_o, 0);
      checkOutput("idle_busy_low", {read_o, write_o}, 0);
      resp_i  = 1'($urandom_range(0, 1));
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
  endtask

  // One line transaction. Called 1ns after a rising edge in an idle cycle.
  // gap < 0 selects a random 0..3 stall before each beat.
  task automatic applyStimulus(input bit doWrite, input bit doRead, input logic [31:0] addr,
                               input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] memLine,
                               input int gap, input int abortAfter, input bit dropEarly);
    logic [LINE_W-1:0] expLine;
    logic [31:0]       expAddr;
    int beatIdx;
    int stall;
    int respSeen;
    bit done;
    expAddr  = addr & 32'hFFFF_FFE0;
    expLine  = doWrite ? lastReadLine : memLine;
    beatIdx  = 0;
    respSeen = 0;
    done     = 1'b0;
    stall    = (gap < 0) ? $urandom_range(0, 3) : gap;
    address_i = addr;
    line_i    = wline;
    write_i   = doWrite;
    read_i    = doRead;
    for (int cycle = 1; cycle <= 200 && !done; cycle++) begin
      @(negedge clk);
      checkOutput("rd_wr_exclusive", read_o & write_o, 0);
      if (doWrite) checkOutput("no_read_o_on_write", read_o, 0);
      if (cycle == 1) begin
        checkOutput("req_cycle_resp_low", resp_o, 0);
        checkOutput("req_cycle_busy_low", {read_o, write_o}, 0);
      end
      if (resp_o) begin
        respSeen++;
        checkOutput("beats_before_resp", beatIdx, BEATS);
        checkOutput("burst_ended", {read_o, write_o}, 0);
        checkOutput("line_o", line_o, expLine);
        if (gap == 0) checkOutput("latency", cycle, 6);
        if (!doWrite) lastReadLine = memLine;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        done    = 1'b1;
        @(posedge clk); #1;
      end else if (abortAfter > 0 && beatIdx == abortAfter) begin
        rst     = 1'b0;
        resp_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        #1;
        checkOutput("abort_outputs", {resp_o, read_o, write_o, burst_o, address_o}, 0);
        checkOutput("abort_line_o", line_o, 0);
        @(posedge clk); #1;
        checkOutput("abort_outputs_edge", {resp_o, read_o, write_o, burst_o, address_o}, 0);
        lastReadLine = '0;
        @(negedge clk);
        rst  = 1'b1;
        done = 1'b1;
        @(posedge clk); #1;
      end else begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        if (read_o || write_o) begin
          checkOutput("address_o", address_o, expAddr);
          checkOutput("busy_kind", {read_o, write_o}, doWrite ? 2'b01 : 2'b10);
          if (doWrite && beatIdx < BEATS)
            checkOutput("burst_o", burst_o, wline[BURST_W*beatIdx +: BURST_W]);
          if (beatIdx < BEATS) begin
            if (stall > 0) begin
              stall--;
            end else begin
              resp_i  = 1'b1;
              burst_i = doWrite ? {$urandom, $urandom} : memLine[BURST_W*beatIdx +: BURST_W];
              beatIdx++;
              stall = (gap < 0) ? $urandom_range(0, 3) : gap;
              if (dropEarly) begin
                read_i  = 1'b0;
                write_i = 1'b0;
              end
            end
          end
        end
      end
    end
    if (!done) begin
      checkOutput("timeout_resp", respSeen, 1);
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      lastReadLine = '0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [LINE_W-1:0] patLine;
    logic [LINE_W-1:0] abcdLine;
    bit wr;
    bit rd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {resp_o, read_o, write_o, burst_o, address_o}, 0);
    checkOutput("reset_line_o", line_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < BEATS; k++) patLine[64*k +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, '0, patLine, 0, 0, 1'b0);
    idleCycles(2);

    abcdLine = {64'hDDDD_0000_0000_DDDD, 64'hCCCC_0000_0000_CCCC,
                64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA};
    applyStimulus(1'b1, 1'b0, 32'h8000_003F, abcdLine, randomLine(), 0, 0, 1'b0);
    idleCycles(1);

    applyStimulus(1'b0, 1'b1, $urandom, '0, randomLine(), 3, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, $urandom, randomLine(), randomLine(), 3, 0, 1'b0);
    idleCycles(1);

    applyStimulus(1'b1, 1'b1, $urandom, randomLine(), randomLine(), 0, 0, 1'b0);
    idleCycles(1);

    applyStimulus(1'b0, 1'b1, $urandom, '0, randomLine(), 0, 2, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, '0, randomLine(), 0, 0, 1'b0);

    applyStimulus(1'b0, 1'b1, $urandom, '0, randomLine(), 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, $urandom, randomLine(), randomLine(), 0, 0, 1'b0);

    applyStimulus(1'b0, 1'b1, $urandom, '0, randomLine(), -1, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, $urandom, randomLine(), randomLine(), -1, 0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(wr, rd, $urandom, randomLine(), randomLine(),
                    ($urandom_range(0, 2) == 0) ? 0 : -1, 0, 1'b0);
      idleCycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
